// File: rtl/engine_inv_cipher_if.sv
// Request/response bundle between the AES engine top level and the inverse cipher.
// The requester drives start, ciphertext and the eleven round keys; the cipher answers.
interface engine_inv_cipher_if;
  logic         transformer_start;
  logic [127:0] block_in;
  logic [127:0] round0_key;
  logic [127:0] round1_key;
  logic [127:0] round2_key;
  logic [127:0] round3_key;
  logic [127:0] round4_key;
  logic [127:0] round5_key;
  logic [127:0] round6_key;
  logic [127:0] round7_key;
  logic [127:0] round8_key;
  logic [127:0] round9_key;
  logic [127:0] round10_key;
  logic [127:0] block_out;
  logic         transformer_done;
  logic         busy;

  modport master (
    output transformer_start, block_in,
    output round0_key, round1_key, round2_key, round3_key, round4_key, round5_key,
    output round6_key, round7_key, round8_key, round9_key, round10_key,
    input  block_out, transformer_done, busy
  );

  modport slave (
    input  transformer_start, block_in,
    input  round0_key, round1_key, round2_key, round3_key, round4_key, round5_key,
    input  round6_key, round7_key, round8_key, round9_key, round10_key,
    output block_out, transformer_done, busy
  );
endinterface

// File: rtl/engine_inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys consumed 10 down to 0.
// Start sampled at E0 yields block_out and transformer_done at E10.
module engine_inv_cipher #(
  parameter bit HOLD_DONE = 1'b0
) (
  input logic               clk,
  input logic               rst_,
  engine_inv_cipher_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [127:0] round_key;

  function automatic logic [7:0] inv_sbox(logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    // Low nibble picks the byte within the row, leftmost byte first.
    row = row << {b[3:0], 3'b000};
    return row[127:120];
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a coefficient whose bits select a, 2a, 4a, 8a (covers 09/0b/0d/0e).
  function automatic logic [7:0] gmul_c(logic [7:0] a, logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[3]}} & x8) ^ ({8{c[2]}} & x4) ^ ({8{c[1]}} & x2) ^ ({8{c[0]}} & a);
  endfunction

  function automatic logic [127:0] inv_shift_rows(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul_c(a0, 4'he) ^ gmul_c(a1, 4'hb) ^ gmul_c(a2, 4'hd) ^ gmul_c(a3, 4'h9);
      o[119 - 32 * c -: 8] = gmul_c(a0, 4'h9) ^ gmul_c(a1, 4'he) ^ gmul_c(a2, 4'hb) ^ gmul_c(a3, 4'hd);
      o[111 - 32 * c -: 8] = gmul_c(a0, 4'hd) ^ gmul_c(a1, 4'h9) ^ gmul_c(a2, 4'he) ^ gmul_c(a3, 4'hb);
      o[103 - 32 * c -: 8] = gmul_c(a0, 4'hb) ^ gmul_c(a1, 4'hd) ^ gmul_c(a2, 4'h9) ^ gmul_c(a3, 4'he);
    end
    return o;
  endfunction

  always_comb begin
    round_key = '0;
    case (cnt_q)
      4'd0:    round_key = bus.round0_key;
      4'd1:    round_key = bus.round1_key;
      4'd2:    round_key = bus.round2_key;
      4'd3:    round_key = bus.round3_key;
      4'd4:    round_key = bus.round4_key;
      4'd5:    round_key = bus.round5_key;
      4'd6:    round_key = bus.round6_key;
      4'd7:    round_key = bus.round7_key;
      4'd8:    round_key = bus.round8_key;
      4'd9:    round_key = bus.round9_key;
      4'd10:   round_key = bus.round10_key;
      default: round_key = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = HOLD_DONE ? done_q : 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.transformer_start) begin
          st_d    = bus.block_in ^ bus.round10_key;
          cnt_d   = 4'd9;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = StRound;
        end
      end
      StRound: begin
        st_d  = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ round_key);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StFinal;
      end
      StFinal: begin
        out_d   = inv_sub_bytes(inv_shift_rows(st_q)) ^ bus.round0_key;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.block_out        = out_q;
  assign bus.transformer_done = done_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_engine_inv_cipher.sv
// Directed bench: pulse-done and held-done builds driven with identical stimulus; round keys and
// the second ciphertext come from a forward AES-128 model with an algebraically built S-box.
module tb_engine_inv_cipher;

  logic clk;
  logic rst_;
  int   n_tests;
  int   n_fail;

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Key2 = 128'h2475a2b33475568831e2120013aa5487;
  localparam logic [127:0] Pt2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Pt3  = 128'h0123456789abcdeffedcba9876543210;

  engine_inv_cipher_if if0 ();
  engine_inv_cipher_if if1 ();

  engine_inv_cipher #(.HOLD_DONE(1'b0)) dut0 (.clk(clk), .rst_(rst_), .bus(if0));
  engine_inv_cipher #(.HOLD_DONE(1'b1)) dut1 (.clk(clk), .rst_(rst_), .bus(if1));

  assign if1.transformer_start = if0.transformer_start;
  assign if1.block_in          = if0.block_in;
  assign if1.round0_key        = if0.round0_key;
  assign if1.round1_key        = if0.round1_key;
  assign if1.round2_key        = if0.round2_key;
  assign if1.round3_key        = if0.round3_key;
  assign if1.round4_key        = if0.round4_key;
  assign if1.round5_key        = if0.round5_key;
  assign if1.round6_key        = if0.round6_key;
  assign if1.round7_key        = if0.round7_key;
  assign if1.round8_key        = if0.round8_key;
  assign if1.round9_key        = if0.round9_key;
  assign if1.round10_key       = if0.round10_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_m   [11];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] r, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      r  = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, xb);
      sbox_t[x] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
                  ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] encrypt(logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_m[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[127 - 8 * i -: 8] = sbox_t[s[127 - 8 * i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[127 - 8 * (4 * c + r) -: 8] = t[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127 - 32 * c -: 8];
          a1 = s[119 - 32 * c -: 8];
          a2 = s[111 - 32 * c -: 8];
          a3 = s[103 - 32 * c -: 8];
          s[127 - 32 * c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[119 - 32 * c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[111 - 32 * c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[103 - 32 * c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      s = s ^ rk_m[rnd];
    end
    return s;
  endfunction

  task automatic apply_keys();
    if0.round0_key  = rk_m[0];
    if0.round1_key  = rk_m[1];
    if0.round2_key  = rk_m[2];
    if0.round3_key  = rk_m[3];
    if0.round4_key  = rk_m[4];
    if0.round5_key  = rk_m[5];
    if0.round6_key  = rk_m[6];
    if0.round7_key  = rk_m[7];
    if0.round8_key  = rk_m[8];
    if0.round9_key  = rk_m[9];
    if0.round10_key = rk_m[10];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  logic [127:0] ct2, ct3;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_    = 1'b1;
    if0.transformer_start = 1'b0;
    if0.block_in          = '0;
    build_sbox();
    expand_key(Key2);
    ct2 = encrypt(Pt2);
    expand_key(Key1);
    ct3 = encrypt(Pt3);
    apply_keys();
    tick();
    tick();
    rst_ = 1'b0;
    check_bit("rst_busy", if0.busy, 1'b0);
    check_bit("rst_done0", if0.transformer_done, 1'b0);
    check_bit("rst_done1", if1.transformer_done, 1'b0);
    check_vec("rst_out", if0.block_out, '0);

    // FIPS-197 C.1 vector, start pulsed for one edge.
    if0.block_in = Ct1;
    if0.transformer_start = 1'b1;
    tick();
    if0.transformer_start = 1'b0;
    check_bit("c1_busy_e0", if0.busy, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_bit("c1_no_early_done", if0.transformer_done, 1'b0);
      check_bit("c1_busy_mid", if0.busy, 1'b1);
    end
    check_vec("c1_out_held_e9", if0.block_out, '0);
    tick();
    check_vec("c1_out_e10", if0.block_out, Pt1);
    check_bit("c1_done0_e10", if0.transformer_done, 1'b1);
    check_bit("c1_done1_e10", if1.transformer_done, 1'b1);
    check_bit("c1_busy_e10", if0.busy, 1'b0);
    tick();
    check_bit("c1_pulse_end", if0.transformer_done, 1'b0);
    check_bit("c1_hold_e11", if1.transformer_done, 1'b1);
    check_vec("c1_out_e11", if0.block_out, Pt1);

    // Second key / model-generated ciphertext.
    expand_key(Key2);
    apply_keys();
    if0.block_in = ct2;
    if0.transformer_start = 1'b1;
    tick();
    if0.transformer_start = 1'b0;
    check_bit("v2_hold_clr_e0", if1.transformer_done, 1'b0);
    for (int k = 1; k <= 10; k++) tick();
    check_vec("v2_out", if0.block_out, Pt2);
    check_vec("v2_out_hold_build", if1.block_out, Pt2);
    check_bit("v2_done0", if0.transformer_done, 1'b1);
    tick();
    check_bit("v2_pulse_end", if0.transformer_done, 1'b0);

    // Start re-asserted at E3 with a different block must be ignored.
    expand_key(Key1);
    apply_keys();
    if0.block_in = Ct1;
    if0.transformer_start = 1'b1;
    tick();
    if0.transformer_start = 1'b0;
    tick();
    tick();
    if0.block_in = 128'hdeadbeefcafef00d0badc0de12345678;
    if0.transformer_start = 1'b1;
    tick();
    if0.transformer_start = 1'b0;
    if0.block_in = Ct1;
    for (int k = 4; k <= 9; k++) tick();
    check_bit("busy_ign_no_done_e9", if0.transformer_done, 1'b0);
    tick();
    check_vec("busy_ign_out", if0.block_out, Pt1);
    check_bit("busy_ign_done", if0.transformer_done, 1'b1);
    tick();
    check_bit("busy_ign_idle", if0.busy, 1'b0);

    // Reset at E5 aborts; no done afterwards; fresh start completes.
    if0.transformer_start = 1'b1;
    tick();
    if0.transformer_start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    check_bit("mid_rst_busy", if0.busy, 1'b0);
    check_vec("mid_rst_out", if0.block_out, '0);
    check_bit("mid_rst_done0", if0.transformer_done, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_bit("mid_rst_no_done", if0.transformer_done, 1'b0);
    end
    if0.transformer_start = 1'b1;
    tick();
    if0.transformer_start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check_vec("post_rst_out", if0.block_out, Pt1);
    check_bit("post_rst_done", if0.transformer_done, 1'b1);

    // Start held high: accepted at E0 and E11, results at E10 and E21.
    tick();
    if0.block_in = Ct1;
    if0.transformer_start = 1'b1;
    tick();
    if0.block_in = ct3;
    for (int k = 1; k <= 10; k++) tick();
    check_vec("b2b_out_e10", if0.block_out, Pt1);
    check_bit("b2b_done0_e10", if0.transformer_done, 1'b1);
    check_bit("b2b_done1_e10", if1.transformer_done, 1'b1);
    tick();
    check_bit("b2b_busy_e11", if0.busy, 1'b1);
    check_bit("b2b_done0_e11", if0.transformer_done, 1'b0);
    check_bit("b2b_done1_e11", if1.transformer_done, 1'b0);
    for (int k = 12; k <= 21; k++) tick();
    if0.transformer_start = 1'b0;
    check_vec("b2b_out_e21", if0.block_out, Pt3);
    check_bit("b2b_done0_e21", if0.transformer_done, 1'b1);
    check_bit("b2b_done1_e21", if1.transformer_done, 1'b1);
    tick();
    check_bit("b2b_busy_e22", if0.busy, 1'b0);
    check_bit("b2b_hold_e22", if1.transformer_done, 1'b1);
    check_bit("b2b_pulse_e22", if0.transformer_done, 1'b0);

    // Reset while idle with held done high.
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    check_bit("idle_rst_done1", if1.transformer_done, 1'b0);
    check_vec("idle_rst_out1", if1.block_out, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
